// File: rtl/bp_me_nonsynth_cce_latency_hist_if.sv
// bp_me_nonsynth_cce_latency_hist_if: sample input and dump output channels of the CCE latency histogram
interface bp_me_nonsynth_cce_latency_hist_if #(
  parameter int lat_width_p   = 16,
  parameter int num_bins_p    = 8,
  parameter int count_width_p = 16
);
  localparam int bin_width_lp = $clog2(num_bins_p);
  logic                     sample_v_i;
  logic                     sample_ready_o;
  logic [1:0]               sample_op_i;
  logic [lat_width_p-1:0]   sample_latency_i;
  logic                     dump_i;
  logic                     dump_v_o;
  logic [1:0]               dump_op_o;
  logic [bin_width_lp-1:0]  dump_bin_o;
  logic [count_width_p-1:0] dump_count_o;
  logic                     dump_yumi_i;
  modport master (
    output sample_v_i, sample_op_i, sample_latency_i, dump_i, dump_yumi_i,
    input  sample_ready_o, dump_v_o, dump_op_o, dump_bin_o, dump_count_o
  );
  modport slave (
    input  sample_v_i, sample_op_i, sample_latency_i, dump_i, dump_yumi_i,
    output sample_ready_o, dump_v_o, dump_op_o, dump_bin_o, dump_count_o
  );
endinterface

// File: rtl/bp_me_nonsynth_cce_latency_hist.sv
// bp_me_nonsynth_cce_latency_hist: per-op log2 latency histogram of completed CCE requests, dumped one bin per handshake
// Optional macro BP_ME_CCE_HIST_CLEAR_ON_DUMP_EN: each dumped bin is zeroed as it is taken, so dumps report per-interval counts.
module bp_me_nonsynth_cce_latency_hist #(
  parameter int lat_width_p   = 16,
  parameter int num_bins_p    = 8,
  parameter int count_width_p = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  bp_me_nonsynth_cce_latency_hist_if.slave   bus,
  output logic                               busy_o,
  output logic [31:0]                        total_samples_o
);
  localparam int num_ops_lp   = 4;
  localparam int bin_width_lp = $clog2(num_bins_p);
  localparam int num_recs_lp  = num_ops_lp * num_bins_p;
  localparam int idx_width_lp = $clog2(num_recs_lp);
  typedef enum logic [1:0] {e_clear, e_ready, e_dump} state_e;
  state_e                   state_r, state_n;
  logic [idx_width_lp-1:0]  index_r;
  logic [count_width_p-1:0] bins_r [num_recs_lp];
  logic [bin_width_lp-1:0]  sample_bin;
  logic [idx_width_lp-1:0]  sample_idx;
  logic                     sample_fire, yumi_fire, last_idx;
  // log2 bin of the incoming latency: highest power of two not exceeding it, clamped to the top bin
  always_comb begin
    sample_bin = '0;
    for (int i = 1; i < num_bins_p; i++)
      if (32'(bus.sample_latency_i) >= (32'd1 << i)) sample_bin = bin_width_lp'(i);
    sample_idx  = {bus.sample_op_i, sample_bin};
    sample_fire = bus.sample_v_i & bus.sample_ready_o;
    yumi_fire   = bus.dump_yumi_i & bus.dump_v_o;
    last_idx    = index_r == idx_width_lp'(num_recs_lp - 1);
  end
  // state register
  always_ff @(posedge clk_i)
    state_r <= reset_i ? e_clear : state_n;
  // next state: clear sweep, idle, dump sweep
  always_comb begin
    state_n = (state_r == e_clear && last_idx)              ? e_ready
            : (state_r == e_ready && bus.dump_i)            ? e_dump
            : (state_r == e_dump && yumi_fire && last_idx)  ? e_ready
            : state_r;
  end
  // outputs decoded from state and the sweep index
  always_comb begin
    bus.sample_ready_o = state_r == e_ready;
    bus.dump_v_o       = state_r == e_dump;
    busy_o             = state_r != e_ready;
    bus.dump_op_o      = index_r[idx_width_lp-1 -: 2];
    bus.dump_bin_o     = index_r[bin_width_lp-1:0];
    bus.dump_count_o   = bins_r[index_r];
  end
  // sweep index, op-major bin-minor; wraps to 0 after the last record
  always_ff @(posedge clk_i)
    if (reset_i) index_r <= '0;
    else if (state_r == e_clear || yumi_fire) index_r <= index_r + 1'b1;
    else if (state_r == e_ready) index_r <= '0;
  // bin counters: zeroed by the clear sweep, saturating increment on each accepted sample
  always_ff @(posedge clk_i)
    if (state_r == e_clear) bins_r[index_r] <= '0;
    else if (sample_fire && bins_r[sample_idx] != '1) bins_r[sample_idx] <= bins_r[sample_idx] + 1'b1;
`ifdef BP_ME_CCE_HIST_CLEAR_ON_DUMP_EN
    else if (yumi_fire) bins_r[index_r] <= '0;
`else
    else bins_r[index_r] <= bins_r[index_r];
`endif
  // saturating count of accepted samples since reset
  always_ff @(posedge clk_i)
    if (reset_i) total_samples_o <= '0;
    else if (sample_fire && total_samples_o != '1) total_samples_o <= total_samples_o + 1'b1;
endmodule

// File: tb/tb_bp_me_nonsynth_cce_latency_hist.sv
// tb_bp_me_nonsynth_cce_latency_hist: scoreboard bench for the CCE latency histogram
module tb_bp_me_nonsynth_cce_latency_hist;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy;
  logic [31:0] total;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] hist [32];
  typedef struct packed {logic [1:0] op; logic [2:0] bin; logic [15:0] count;} rec_t;
  rec_t exp_q[$];
  rec_t prev, cur, e;
  logic pv = 1'b0;
  bp_me_nonsynth_cce_latency_hist_if #(.lat_width_p(16), .num_bins_p(8), .count_width_p(16)) bus();
  bp_me_nonsynth_cce_latency_hist dut (
    .clk_i(clk),
    .reset_i(reset),
    .bus(bus),
    .busy_o(busy),
    .total_samples_o(total)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    bus.sample_v_i = 1'b0;
    bus.dump_i = 1'b0;
    bus.dump_yumi_i = 1'b0;
    tick;
    chk("reset_dump_v", 32'(bus.dump_v_o), 0);
    chk("reset_total", total, 0);
    tick;
    reset = 1'b0;
    for (int c = 0; c <= 32; c++) begin
      chk("clear_ready", 32'(bus.sample_ready_o), 32'(c == 32));
      chk("clear_busy", 32'(busy), 32'(c != 32));
      if (c < 32) tick;
    end
    foreach (hist[i]) hist[i] = '0;
  endtask
  task automatic send(input logic [1:0] op, input logic [15:0] lat);
    chk("send_ready", 32'(bus.sample_ready_o), 1);
    bus.sample_v_i = 1'b1;
    bus.sample_op_i = op;
    bus.sample_latency_i = lat;
    tick;
    bus.sample_v_i = 1'b0;
  endtask
  task automatic dump(input bit toggle, input int nrec);
    for (int i = 0; i < nrec; i++) exp_q.push_back('{op: 2'(i >> 3), bin: 3'(i), count: hist[i]});
    bus.dump_i = 1'b1;
    tick;
    bus.dump_i = 1'b0;
    bus.sample_v_i = 1'b0;
    chk("dump_first_v", 32'(bus.dump_v_o), 1);
    for (int k = 0; k < (toggle ? 2 * nrec : nrec); k++) begin
      bus.dump_yumi_i = toggle ? k[0] : 1'b1;
      tick;
    end
    bus.dump_yumi_i = 1'b0;
    if (nrec == 32) begin
      chk("dump_done_ready", 32'(bus.sample_ready_o), 1);
      chk("dump_done_v", 32'(bus.dump_v_o), 0);
    end
`ifdef BP_ME_CCE_HIST_CLEAR_ON_DUMP_EN
    for (int i = 0; i < nrec; i++) hist[i] = '0;
`endif
  endtask
  always @(negedge clk) begin
    cur = '{op: bus.dump_op_o, bin: bus.dump_bin_o, count: bus.dump_count_o};
    if (!reset && bus.dump_v_o) begin
      chk("dump_blocks_sample", 32'(bus.sample_ready_o), 0);
      if (pv) chk("dump_hold", 32'(cur), 32'(prev));
      if (bus.dump_yumi_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_record: got op %0d bin %0d count %0d expected none", cur.op, cur.bin, cur.count);
        end else begin
          e = exp_q.pop_front();
          chk("rec_op", 32'(cur.op), 32'(e.op));
          chk("rec_bin", 32'(cur.bin), 32'(e.bin));
          chk("rec_count", 32'(cur.count), 32'(e.count));
        end
      end
    end
    pv = !reset && bus.dump_v_o && !bus.dump_yumi_i;
    prev = cur;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    bus.sample_v_i = 1'b0;
    bus.sample_op_i = '0;
    bus.sample_latency_i = '0;
    bus.dump_i = 1'b0;
    bus.dump_yumi_i = 1'b0;
    do_reset;
    send(2'd0, 16'd5);
    send(2'd0, 16'd7);
    send(2'd1, 16'd0);
    send(2'd3, 16'd1000);
    hist[2] = 16'd2;
    hist[8] = 16'd1;
    hist[31] = 16'd1;
    chk("total_t2", total, 4);
    dump(1'b0, 32);
    dump(1'b1, 32);
    send(2'd0, 16'd1);
    send(2'd0, 16'd2);
    send(2'd0, 16'd3);
    send(2'd1, 16'd127);
    send(2'd1, 16'd128);
    send(2'd2, 16'd65535);
    hist[0] += 16'd1;
    hist[1] += 16'd2;
    hist[14] += 16'd1;
    hist[15] += 16'd1;
    hist[23] += 16'd1;
    dump(1'b0, 32);
    do_reset;
    bus.sample_v_i = 1'b1;
    bus.sample_op_i = 2'd2;
    bus.sample_latency_i = 16'd3;
    repeat (70000) tick;
    bus.sample_v_i = 1'b0;
    chk("total_t4", total, 70000);
    hist[17] = 16'hffff;
    dump(1'b0, 32);
    bus.sample_v_i = 1'b1;
    bus.sample_op_i = 2'd1;
    bus.sample_latency_i = 16'd2;
    hist[9] = 16'd1;
    dump(1'b0, 32);
    chk("total_t5", total, 70001);
    dump(1'b0, 10);
    chk("rec10_op", 32'(bus.dump_op_o), 1);
    chk("rec10_bin", 32'(bus.dump_bin_o), 2);
    do_reset;
    dump(1'b0, 32);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
